fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 72 +++++++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg : shared fetch-stage types and the halt opcode           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [7:0] HALT_OP = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_buffer : synchronous FIFO with flush, count, full and empty  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 12,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W-1:0] c_last  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != c_depth) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_sequencer : PC sequencing and instruction buffering for decode|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int         ADDR_W    = 4,
  parameter int         BUF_DEPTH = 2,
  parameter logic [7:0] HALT_OP   = fetch_pkg::HALT_OP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [7:0]        imem_instr_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [7:0]        instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              busy_o,
  output logic              halted_o
);

  import fetch_pkg::*;

  localparam int ENT_W = 8 + ADDR_W;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_busy;
  logic              r_halted;

  logic [ENT_W-1:0]  w_rdata;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_flush;
  logic [ADDR_W-1:0] w_target;

  assign w_pop = !w_empty && instr_ready_i;

  // Redirect outranks start; a start outside IDLE is a jump to address 0.
  always_comb begin
    w_flush  = 1'b0;
    w_target = '0;
    case (r_state)
      ST_IDLE: begin
        w_flush = start_i;
      end
      default: begin
        w_flush = redirect_valid_i || start_i;
        if (redirect_valid_i) begin
          w_target = redirect_addr_i;
        end
      end
    endcase
  end

  assign w_push = (r_state == ST_FETCH) && !w_flush && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else if (w_flush) begin
      r_state  <= ST_FETCH;
      r_pc     <= w_target;
      r_busy   <= 1'b1;
      r_halted <= 1'b0;
    end else if (w_push) begin
      // The halt opcode is still delivered; the PC stays on it.
      if (imem_instr_i == HALT_OP) begin
        r_state  <= ST_HALTED;
        r_busy   <= 1'b0;
        r_halted <= 1'b1;
      end else begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (w_flush),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({imem_instr_i, r_pc}),
    .rdata (w_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign imem_addr_o   = r_pc;
  assign instr_valid_o = (w_count != '0);
  assign instr_o       = w_rdata[ENT_W-1:ADDR_W];
  assign instr_pc_o    = w_rdata[ADDR_W-1:0];
  assign busy_o        = r_busy;
  assign halted_o      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_sequencer : randomized bench with queue-based fetch model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       redirect_valid_i = 1'b0;
  logic [3:0] redirect_addr_i = 4'h0;
  logic       instr_ready_i = 1'b0;
  logic [3:0] imem_addr_o;
  logic [7:0] imem_instr_i;
  logic       instr_valid_o;
  logic [7:0] instr_o;
  logic [3:0] instr_pc_o;
  logic       busy_o;
  logic       halted_o;

  logic [7:0] mem [16];
  assign imem_instr_i = mem[imem_addr_o];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W    (4),
    .BUF_DEPTH (DEPTH),
    .HALT_OP   (8'hFF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_addr_i  (redirect_addr_i),
    .imem_addr_o      (imem_addr_o),
    .imem_instr_i     (imem_instr_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .busy_o           (busy_o),
    .halted_o         (halted_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of {instr, pc}, PC as an integer, mode 0=idle 1=fetch 2=halted.
  logic [11:0] q[$];
  int          m_pc;
  int          m_mode;

  task automatic model_reset();
    q.delete();
    m_pc   = 0;
    m_mode = 0;
  endtask

  // Applies one clock of the fetch rules to the model, then advances to the next negedge.
  task automatic step();
    logic       pop;
    logic [7:0] op;
    pop = (q.size() > 0) && instr_ready_i;
    if (m_mode == 0) begin
      if (start_i) begin
        q.delete(); m_pc = 0; m_mode = 1;
      end
    end else if (redirect_valid_i) begin
      q.delete(); m_pc = int'(redirect_addr_i); m_mode = 1;
    end else if (start_i) begin
      q.delete(); m_pc = 0; m_mode = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_mode == 1 && q.size() < DEPTH) begin
        op = mem[m_pc];
        q.push_back({op, 4'(m_pc)});
        if (op == 8'hFF) m_mode = 2;
        else m_pc = (m_pc + 1) % 16;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [18:0] exp_vec();
    logic        v;
    logic [11:0] h;
    v = (q.size() > 0);
    h = v ? q[0] : 12'h0;
    return {v, (m_mode == 1), (m_mode == 2), 4'(m_pc), h};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {instr_valid_o, busy_o, halted_o, imem_addr_o,
            instr_valid_o ? {instr_o, instr_pc_o} : 12'h0};
  endfunction

  task automatic test_reset();
    n_tests++;
    if ({instr_valid_o, busy_o, halted_o, imem_addr_o, instr_o, instr_pc_o} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {instr_valid_o, busy_o, halted_o, imem_addr_o, instr_o, instr_pc_o});
    end
    model_reset();
    rst_n = 1'b1;
    instr_ready_i = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_addr_i = 4'h7;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL idle_no_start cyc%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    redirect_valid_i = 1'b0;
  endtask

  task automatic test_halt_program();
    logic [7:0] prog [4];
    prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03; prog[3] = 8'hFF;
    for (int i = 0; i < 16; i++) mem[i] = (i < 4) ? prog[i] : 8'h40 + 8'(i);
    instr_ready_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL halt_prog_model cyc%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      if (k == 1) begin
        n_tests++;
        if (imem_addr_o !== 4'h0 || instr_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL start_latency cyc1: got addr %h valid %b expected addr 0 valid 0",
                   imem_addr_o, instr_valid_o);
        end
      end
      if (k >= 2 && k <= 5) begin
        n_tests++;
        if ({instr_valid_o, instr_o, instr_pc_o} !== {1'b1, prog[k-2], 4'(k-2)}) begin
          n_fail++;
          $display("FAIL halt_prog_seq cyc%0d: got %h expected %h", k,
                   {instr_valid_o, instr_o, instr_pc_o}, {1'b1, prog[k-2], 4'(k-2)});
        end
      end
      if (k >= 5) begin
        n_tests++;
        if (halted_o !== 1'b1 || (k >= 6 && instr_valid_o !== 1'b0)) begin
          n_fail++;
          $display("FAIL halt_state cyc%0d: got halted %b valid %b expected halted 1",
                   k, halted_o, instr_valid_o);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int got [$];
    for (int i = 0; i < 16; i++) mem[i] = 8'h20 + 8'(i);
    instr_ready_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL backpressure_fill cyc%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if ({imem_addr_o, instr_valid_o, instr_pc_o} !== {4'h2, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL backpressure_hold: got addr/valid/pc %h expected %h",
               {imem_addr_o, instr_valid_o, instr_pc_o}, {4'h2, 1'b1, 4'h0});
    end
    instr_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (instr_valid_o) got.push_back(int'(instr_pc_o));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL backpressure_drain cyc%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      step();
    end
    n_tests++;
    if (got.size() != 6 || got[0] != 0 || got[1] != 1 || got[2] != 2 || got[5] != 5) begin
      n_fail++;
      $display("FAIL backpressure_order: got %0d items first %0d expected 6 items pc 0..5",
               got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_redirect();
    instr_ready_i = 1'b0;
    step();
    step();
    n_tests++;
    if (obs_vec() !== exp_vec() || instr_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_prefill: got %h expected %h", obs_vec(), exp_vec());
    end
    redirect_valid_i = 1'b1;
    redirect_addr_i = 4'hA;
    instr_ready_i = 1'b1;
    step();
    redirect_valid_i = 1'b0;
    n_tests++;
    if (instr_valid_o !== 1'b0 || imem_addr_o !== 4'hA) begin
      n_fail++;
      $display("FAIL redirect_flush: got valid %b addr %h expected valid 0 addr a",
               instr_valid_o, imem_addr_o);
    end
    step();
    n_tests++;
    if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 4'hA, 8'h2A}) begin
      n_fail++;
      $display("FAIL redirect_target: got %h expected %h",
               {instr_valid_o, instr_pc_o, instr_o}, {1'b1, 4'hA, 8'h2A});
    end
  endtask

  task automatic test_wrap();
    int got [$];
    redirect_valid_i = 1'b1;
    redirect_addr_i = 4'hE;
    instr_ready_i = 1'b1;
    step();
    redirect_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (instr_valid_o) got.push_back(int'(instr_pc_o));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_model cyc%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      step();
    end
    n_tests++;
    if (got.size() < 4 || got[0] != 14 || got[1] != 15 || got[2] != 0 || got[3] != 1) begin
      n_fail++;
      $display("FAIL wrap_sequence: got %0d items first %0d expected 14,15,0,1",
               got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    instr_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({instr_valid_o, busy_o, halted_o, imem_addr_o, instr_o, instr_pc_o} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected 0",
               {instr_valid_o, busy_o, halted_o, imem_addr_o, instr_o, instr_pc_o});
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({instr_valid_o, busy_o, halted_o, imem_addr_o, instr_o, instr_pc_o} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected 0",
               {instr_valid_o, busy_o, halted_o, imem_addr_o, instr_o, instr_pc_o});
    end
    rst_n = 1'b1;
    instr_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if (instr_valid_o !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_needs_start cyc%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    n_tests++;
    if ({instr_valid_o, instr_pc_o} !== {1'b1, 4'h0} || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_restart: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_halt_redirect_start();
    mem[3] = 8'hFF;
    instr_ready_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL halt_redir_model cyc%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      step();
    end
    n_tests++;
    if (halted_o !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_redir_halted: got %b expected 1", halted_o);
    end
    redirect_valid_i = 1'b1;
    redirect_addr_i = 4'h5;
    start_i = 1'b1;
    instr_ready_i = 1'b0;
    step();
    redirect_valid_i = 1'b0;
    start_i = 1'b0;
    step();
    n_tests++;
    if ({instr_valid_o, instr_pc_o, busy_o} !== {1'b1, 4'h5, 1'b1}) begin
      n_fail++;
      $display("FAIL halt_redir_target: got %h expected %h",
               {instr_valid_o, instr_pc_o, busy_o}, {1'b1, 4'h5, 1'b1});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    for (int k = 0; k < 400; k++) begin
      instr_ready_i    = ($urandom_range(0, 3) != 0);
      redirect_valid_i = ($urandom_range(0, 15) == 0);
      start_i          = ($urandom_range(0, 31) == 0);
      redirect_addr_i  = 4'($urandom_range(0, 15));
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    instr_ready_i = 1'b0;
    redirect_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_halt_program();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_halt_redirect_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
